// File: rtl/dcache_controller.sv
// dcache_controller
// Upstream controller for a 2-way set-associative data-cache SRAM.
// Hits are served combinationally in the request cycle. A miss stalls the CPU,
// optionally writes back a dirty victim line, refills the requested line from
// data memory, installs it in the SRAM and then lets the access replay as a hit.
//
// Handshake contract:
//   CPU side : a request (cpu_MemRead_i | cpu_MemWrite_i) completes in the cycle
//              where cpu_stall_o is low. While cpu_stall_o is high the CPU holds
//              address, data and request stable. Index and tag are always taken
//              live from cpu_addr_i.
//   Memory   : mem_enable_o is held high, with address/data/direction stable,
//              until a single-cycle mem_ack_i pulse. Acks seen in any state other
//              than WRITEBACK or READMISS are ignored.
//   SRAM     : sram_write_o is sampled by the SRAM on the next rising edge.
//              sram_tag_i/sram_data_i show the hit way, or the LRU victim on a miss.

module dcache_controller #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LINE_W = 256,
   parameter int IDX_W  = 4,
   parameter int TAG_W  = 23
) (
   input  logic                clk_i,
   input  logic                rst_i,
   // CPU interface
   input  logic [ADDR_W-1:0]   cpu_addr_i,
   input  logic [DATA_W-1:0]   cpu_data_i,
   input  logic                cpu_MemRead_i,
   input  logic                cpu_MemWrite_i,
   output logic [DATA_W-1:0]   cpu_data_o,
   output logic                cpu_stall_o,
   // cache SRAM interface
   output logic [IDX_W-1:0]    sram_addr_o,
   output logic [TAG_W+1:0]    sram_tag_o,
   output logic [LINE_W-1:0]   sram_data_o,
   output logic                sram_enable_o,
   output logic                sram_write_o,
   input  logic [TAG_W+1:0]    sram_tag_i,
   input  logic [LINE_W-1:0]   sram_data_i,
   input  logic                sram_hit_i,
   // data memory interface
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [LINE_W-1:0]   mem_data_o,
   output logic                mem_enable_o,
   output logic                mem_write_o,
   input  logic [LINE_W-1:0]   mem_data_i,
   input  logic                mem_ack_i,
   // controller state for observation
   output logic [2:0]          dbg_state_o
);

   // Byte offset inside a line and word-select field inside the offset.
   localparam int OFF_W  = 5;
   localparam int WSEL_W = 3;
   localparam int WSEL_LSB = 2;

   // Bit positions inside the {valid, dirty, tag} SRAM tag field.
   localparam int VALID_BIT = TAG_W + 1;
   localparam int DIRTY_BIT = TAG_W;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_MISS      = 3'd1,
      S_WRITEBACK = 3'd2,
      S_READMISS  = 3'd3,
      S_REFILL    = 3'd4
   } state_t;

   state_t              r_state;
   logic                r_mem_enable;
   logic                r_mem_write;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [LINE_W-1:0]   r_mem_data;
   logic [LINE_W-1:0]   r_line_buf;
   logic [TAG_W+1:0]    r_victim_tag;
   logic [LINE_W-1:0]   r_victim_line;

   logic                w_req;
   logic                w_store;
   logic                w_miss;
   logic                w_store_hit;
   logic                w_victim_dirty;
   logic [IDX_W-1:0]    w_idx;
   logic [TAG_W-1:0]    w_tag;
   logic [WSEL_W-1:0]   w_word_sel;
   logic [LINE_W-1:0]   w_store_line;
   logic [ADDR_W-1:0]   w_refill_addr;
   logic [ADDR_W-1:0]   w_wb_addr;
   logic                w_unused;

   // Address decode; the low two byte bits are don't-care for word accesses.
   assign w_idx      = cpu_addr_i[OFF_W +: IDX_W];
   assign w_tag      = cpu_addr_i[ADDR_W-1 -: TAG_W];
   assign w_word_sel = cpu_addr_i[WSEL_LSB +: WSEL_W];
   assign w_unused   = ^cpu_addr_i[WSEL_LSB-1:0];

   // A simultaneous read and write request is handled as a store.
   assign w_req       = cpu_MemRead_i | cpu_MemWrite_i;
   assign w_store     = cpu_MemWrite_i;
   assign w_miss      = w_req & ~sram_hit_i;
   assign w_store_hit = (r_state == S_IDLE) & w_req & sram_hit_i & w_store;

   // Victim needs a write-back only when it holds live, modified data.
   assign w_victim_dirty = r_victim_tag[VALID_BIT] & r_victim_tag[DIRTY_BIT];

   // Line-aligned memory addresses for the refill read and the victim write-back.
   assign w_refill_addr = {w_tag, w_idx, {OFF_W{1'b0}}};
   assign w_wb_addr     = {r_victim_tag[TAG_W-1:0], w_idx, {OFF_W{1'b0}}};

   // Store-hit line: current SRAM line with the addressed word replaced.
   always_comb begin
      w_store_line = sram_data_i;
      w_store_line[w_word_sel*DATA_W +: DATA_W] = cpu_data_i;
   end

   // CPU side: load data is the selected word of whatever the SRAM presents.
   assign cpu_data_o  = sram_data_i[w_word_sel*DATA_W +: DATA_W];
   assign cpu_stall_o = (r_state != S_IDLE) | w_miss;

   // SRAM control: looked up on any idle request, written on store hit or refill.
   assign sram_addr_o   = w_idx;
   assign sram_enable_o = ((r_state == S_IDLE) & w_req) | (r_state == S_REFILL);
   assign sram_write_o  = ~rst_i & (w_store_hit | (r_state == S_REFILL));

   // SRAM write payload: refill installs a clean line, a store hit marks it dirty.
   always_comb begin
      sram_data_o = w_store_line;
      sram_tag_o  = {1'b1, 1'b1, w_tag};
      if (r_state == S_REFILL) begin
         sram_data_o = r_line_buf;
         sram_tag_o  = {1'b1, 1'b0, w_tag};
      end
   end

   // Memory side outputs come straight from registers.
   assign mem_addr_o   = r_mem_addr;
   assign mem_data_o   = r_mem_data;
   assign mem_enable_o = r_mem_enable;
   assign mem_write_o  = r_mem_write;

   assign dbg_state_o = r_state;

   // Miss-handling FSM with registered memory request outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state       <= S_IDLE;
         r_mem_enable  <= 1'b0;
         r_mem_write   <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_data    <= '0;
         r_line_buf    <= '0;
         r_victim_tag  <= '0;
         r_victim_line <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // Capture the LRU victim while the SRAM is still showing it.
               if (w_miss) begin
                  r_victim_tag  <= sram_tag_i;
                  r_victim_line <= sram_data_i;
                  r_state       <= S_MISS;
               end
            end
            S_MISS: begin
               r_mem_enable <= 1'b1;
               if (w_victim_dirty) begin
                  r_mem_addr  <= w_wb_addr;
                  r_mem_data  <= r_victim_line;
                  r_mem_write <= 1'b1;
                  r_state     <= S_WRITEBACK;
               end else begin
                  r_mem_addr  <= w_refill_addr;
                  r_mem_write <= 1'b0;
                  r_state     <= S_READMISS;
               end
            end
            S_WRITEBACK: begin
               // Write-back done: keep the request up and turn it into the refill read.
               if (mem_ack_i) begin
                  r_mem_addr  <= w_refill_addr;
                  r_mem_write <= 1'b0;
                  r_state     <= S_READMISS;
               end
            end
            S_READMISS: begin
               if (mem_ack_i) begin
                  r_line_buf   <= mem_data_i;
                  r_mem_enable <= 1'b0;
                  r_state      <= S_REFILL;
               end
            end
            S_REFILL: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller
// Directed bench: the SRAM and data memory are played by the bench, which
// drives hit/victim/refill values by hand and checks the controller's reaction.

module tb_dcache_controller;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_MISS = 3'd1;
   localparam logic [2:0] ST_WB   = 3'd2;
   localparam logic [2:0] ST_RM   = 3'd3;
   localparam logic [2:0] ST_RF   = 3'd4;

   logic          clk;
   logic          rst;
   logic [31:0]   cpu_addr;
   logic [31:0]   cpu_wdata;
   logic          cpu_rd;
   logic          cpu_wr;
   logic [31:0]   cpu_rdata;
   logic          cpu_stall;
   logic [3:0]    sram_addr;
   logic [24:0]   sram_tag_o;
   logic [255:0]  sram_data_o;
   logic          sram_en;
   logic          sram_wr;
   logic [24:0]   sram_tag_i;
   logic [255:0]  sram_data_i;
   logic          sram_hit;
   logic [31:0]   mem_addr;
   logic [255:0]  mem_data_o;
   logic          mem_en;
   logic          mem_wr;
   logic [255:0]  mem_data_i;
   logic          mem_ack;
   logic [2:0]    dbg_state;

   int n_checks;
   int n_pass;

   // stall / SRAM-write counters sampled on the falling edge while enabled
   logic mon_en;
   int   mon_stall;
   int   mon_wr;

   dcache_controller dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .cpu_addr_i     (cpu_addr),
      .cpu_data_i     (cpu_wdata),
      .cpu_MemRead_i  (cpu_rd),
      .cpu_MemWrite_i (cpu_wr),
      .cpu_data_o     (cpu_rdata),
      .cpu_stall_o    (cpu_stall),
      .sram_addr_o    (sram_addr),
      .sram_tag_o     (sram_tag_o),
      .sram_data_o    (sram_data_o),
      .sram_enable_o  (sram_en),
      .sram_write_o   (sram_wr),
      .sram_tag_i     (sram_tag_i),
      .sram_data_i    (sram_data_i),
      .sram_hit_i     (sram_hit),
      .mem_addr_o     (mem_addr),
      .mem_data_o     (mem_data_o),
      .mem_enable_o   (mem_en),
      .mem_write_o    (mem_wr),
      .mem_data_i     (mem_data_i),
      .mem_ack_i      (mem_ack),
      .dbg_state_o    (dbg_state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mon_en) begin
         if (cpu_stall) mon_stall++;
         if (sram_wr) mon_wr++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cpu_rd      = 1'b0;
      cpu_wr      = 1'b0;
      cpu_addr    = '0;
      cpu_wdata   = '0;
      sram_hit    = 1'b0;
      sram_tag_i  = '0;
      sram_data_i = '0;
      mem_ack     = 1'b0;
      mem_data_i  = '0;
   endtask

   function automatic logic [255:0] make_line(input logic [31:0] base);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
      return l;
   endfunction

   // Driver: a clean (no write-back) load miss with one-cycle memory latency,
   // ending in the replay cycle with the SRAM reporting a hit on the new line.
   task automatic clean_miss(input logic [31:0] addr, input logic [255:0] line,
                             output logic [31:0] seen_addr, output logic [24:0] seen_tag);
      cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = addr;
      sram_hit = 1'b0; sram_tag_i = '0; sram_data_i = '0;
      tick();                       // MISS
      tick();                       // READMISS
      seen_addr = mem_addr;
      mem_data_i = line; mem_ack = 1'b1;
      tick();                       // REFILL
      mem_ack = 1'b0;
      seen_tag = sram_tag_o;
      tick();                       // IDLE, replay
      sram_hit = 1'b1; sram_data_i = line; sram_tag_i = seen_tag;
      #1;
   endtask

   task automatic test_reset();
      n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
      n_checks++; if (mem_en !== 1'b0) $display("FAIL reset_mem_en: got %b want 0", mem_en); else n_pass++;
      n_checks++; if (mem_wr !== 1'b0) $display("FAIL reset_mem_wr: got %b want 0", mem_wr); else n_pass++;
      n_checks++; if (sram_wr !== 1'b0) $display("FAIL reset_sram_wr: got %b want 0", sram_wr); else n_pass++;
      n_checks++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else n_pass++;
      n_checks++; if (mem_data_o !== 256'h0) $display("FAIL reset_mem_data: got %h want 0", mem_data_o); else n_pass++;
   endtask

   task automatic test_cold_load();
      logic [255:0] l1;
      l1 = make_line(32'h1111_0000);
      l1[95:64] = 32'hDEAD_BEEF;
      cpu_rd = 1'b1; cpu_addr = 32'h0000_0040;
      sram_hit = 1'b0; sram_tag_i = '0; sram_data_i = '0;
      #1;
      n_checks++; if (cpu_stall !== 1'b1) $display("FAIL cold_stall: got %b want 1", cpu_stall); else n_pass++;
      n_checks++; if (sram_en !== 1'b1) $display("FAIL cold_sram_en: got %b want 1", sram_en); else n_pass++;
      n_checks++; if (sram_addr !== 4'd2) $display("FAIL cold_sram_addr: got %h want 2", sram_addr); else n_pass++;
      tick();
      n_checks++; if (dbg_state !== ST_MISS) $display("FAIL cold_miss_state: got %0d want %0d", dbg_state, ST_MISS); else n_pass++;
      n_checks++; if (sram_en !== 1'b0) $display("FAIL cold_miss_sram_en: got %b want 0", sram_en); else n_pass++;
      tick();
      n_checks++; if (dbg_state !== ST_RM) $display("FAIL cold_rm_state: got %0d want %0d", dbg_state, ST_RM); else n_pass++;
      n_checks++; if ({mem_en, mem_wr} !== 2'b10) $display("FAIL cold_mem_ctl: got %b want 10", {mem_en, mem_wr}); else n_pass++;
      n_checks++; if (mem_addr !== 32'h0000_0040) $display("FAIL cold_mem_addr: got %h want 00000040", mem_addr); else n_pass++;
      mem_data_i = l1; mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      n_checks++; if (sram_wr !== 1'b1) $display("FAIL cold_refill_wr: got %b want 1", sram_wr); else n_pass++;
      n_checks++; if (sram_data_o !== l1) $display("FAIL cold_refill_data: got %h want %h", sram_data_o, l1); else n_pass++;
      n_checks++; if (sram_tag_o !== 25'h100_0000) $display("FAIL cold_refill_tag: got %h want 1000000", sram_tag_o); else n_pass++;
      n_checks++; if (mem_en !== 1'b0) $display("FAIL cold_refill_mem_en: got %b want 0", mem_en); else n_pass++;
      tick();
      cpu_addr = 32'h0000_0048; sram_hit = 1'b1; sram_data_i = l1; sram_tag_i = 25'h100_0000;
      #1;
      n_checks++; if (cpu_rdata !== 32'hDEAD_BEEF) $display("FAIL cold_hit_data: got %h want deadbeef", cpu_rdata); else n_pass++;
      n_checks++; if (cpu_stall !== 1'b0) $display("FAIL cold_hit_stall: got %b want 0", cpu_stall); else n_pass++;
      n_checks++; if (sram_wr !== 1'b0) $display("FAIL cold_hit_sram_wr: got %b want 0", sram_wr); else n_pass++;
      tick();
   endtask

   task automatic test_store_hit();
      logic [255:0] l1;
      logic [255:0] exp_line;
      l1 = make_line(32'h2222_0000);
      exp_line = l1;
      exp_line[63:32] = 32'h1234_5678;
      cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 32'h0000_0044; cpu_wdata = 32'h1234_5678;
      sram_hit = 1'b1; sram_data_i = l1; sram_tag_i = 25'h100_0000;
      #1;
      n_checks++; if (sram_wr !== 1'b1) $display("FAIL store_sram_wr: got %b want 1", sram_wr); else n_pass++;
      n_checks++; if (sram_data_o !== exp_line) $display("FAIL store_data: got %h want %h", sram_data_o, exp_line); else n_pass++;
      n_checks++; if (sram_tag_o !== 25'h180_0000) $display("FAIL store_tag: got %h want 1800000", sram_tag_o); else n_pass++;
      n_checks++; if (cpu_stall !== 1'b0) $display("FAIL store_stall: got %b want 0", cpu_stall); else n_pass++;
      cpu_rd = 1'b1;
      #1;
      n_checks++; if (sram_wr !== 1'b1) $display("FAIL store_rdwr_both: got %b want 1", sram_wr); else n_pass++;
      tick();
      n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL store_state: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
      idle_inputs();
      tick();
   endtask

   task automatic test_dirty_victim();
      logic [255:0] lv;
      logic [255:0] lr;
      lv = make_line(32'h3333_0000);
      lr = make_line(32'h4444_0000);
      cpu_rd = 1'b1; cpu_addr = 32'h0000_0440;
      sram_hit = 1'b0; sram_tag_i = 25'h180_0001; sram_data_i = lv;
      tick();                       // MISS
      tick();                       // WRITEBACK
      n_checks++; if (dbg_state !== ST_WB) $display("FAIL dirty_wb_state: got %0d want %0d", dbg_state, ST_WB); else n_pass++;
      n_checks++; if ({mem_en, mem_wr} !== 2'b11) $display("FAIL dirty_wb_ctl: got %b want 11", {mem_en, mem_wr}); else n_pass++;
      n_checks++; if (mem_addr !== 32'h0000_0240) $display("FAIL dirty_wb_addr: got %h want 00000240", mem_addr); else n_pass++;
      n_checks++; if (mem_data_o !== lv) $display("FAIL dirty_wb_data: got %h want %h", mem_data_o, lv); else n_pass++;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      n_checks++; if ({mem_en, mem_wr} !== 2'b10) $display("FAIL dirty_rd_ctl: got %b want 10", {mem_en, mem_wr}); else n_pass++;
      n_checks++; if (mem_addr !== 32'h0000_0440) $display("FAIL dirty_rd_addr: got %h want 00000440", mem_addr); else n_pass++;
      mem_data_i = lr; mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      n_checks++; if (sram_data_o !== lr) $display("FAIL dirty_refill_data: got %h want %h", sram_data_o, lr); else n_pass++;
      n_checks++; if (sram_tag_o !== 25'h100_0002) $display("FAIL dirty_refill_tag: got %h want 1000002", sram_tag_o); else n_pass++;
      tick();
      sram_hit = 1'b1; sram_data_i = lr; sram_tag_i = 25'h100_0002;
      #1;
      n_checks++; if (cpu_stall !== 1'b0) $display("FAIL dirty_hit_stall: got %b want 0", cpu_stall); else n_pass++;
      n_checks++; if (cpu_rdata !== 32'h4444_0000) $display("FAIL dirty_hit_data: got %h want 44440000", cpu_rdata); else n_pass++;
      idle_inputs();
      tick();
   endtask

   task automatic test_latency(input int lat);
      logic [255:0] lv;
      logic [255:0] lr;
      logic held_ok;
      lv = make_line(32'h5555_0000) ^ 256'(lat);
      lr = make_line(32'h6666_0000) ^ 256'(lat);
      held_ok = 1'b1;
      mon_stall = 0; mon_wr = 0; mon_en = 1'b1;
      cpu_rd = 1'b1; cpu_addr = 32'h0000_0080;
      sram_hit = 1'b0; sram_tag_i = 25'h180_0005; sram_data_i = lv;
      tick();                       // MISS
      tick();                       // WRITEBACK
      for (int c = 0; c < lat; c++) begin
         if (mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 32'h0000_0A80 ||
             mem_data_o !== lv || dbg_state !== ST_WB) held_ok = 1'b0;
         if (c == lat - 1) mem_ack = 1'b1;
         tick();
         mem_ack = 1'b0;
      end
      mem_data_i = lr;
      for (int c = 0; c < lat; c++) begin
         if (mem_en !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'h0000_0080 ||
             dbg_state !== ST_RM) held_ok = 1'b0;
         if (c == lat - 1) mem_ack = 1'b1;
         tick();
         mem_ack = 1'b0;
      end
      n_checks++; if (dbg_state !== ST_RF) $display("FAIL lat%0d_refill_state: got %0d want %0d", lat, dbg_state, ST_RF); else n_pass++;
      tick();
      sram_hit = 1'b1; sram_data_i = lr; sram_tag_i = 25'h100_0000;
      @(negedge clk);
      #1;
      mon_en = 1'b0;
      n_checks++; if (held_ok !== 1'b1) $display("FAIL lat%0d_held: got %b want 1", lat, held_ok); else n_pass++;
      n_checks++; if (mon_stall !== 3 + 2 * lat) $display("FAIL lat%0d_stall_cycles: got %0d want %0d", lat, mon_stall, 3 + 2 * lat); else n_pass++;
      n_checks++; if (mon_wr !== 1) $display("FAIL lat%0d_refill_writes: got %0d want 1", lat, mon_wr); else n_pass++;
      n_checks++; if (cpu_rdata !== lr[31:0]) $display("FAIL lat%0d_hit_data: got %h want %h", lat, cpu_rdata, lr[31:0]); else n_pass++;
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_mid_writeback();
      cpu_rd = 1'b1; cpu_addr = 32'h0000_0440;
      sram_hit = 1'b0; sram_tag_i = 25'h180_0001; sram_data_i = make_line(32'h7777_0000);
      tick();
      tick();
      n_checks++; if (dbg_state !== ST_WB) $display("FAIL rstwb_pre_state: got %0d want %0d", dbg_state, ST_WB); else n_pass++;
      #2;
      rst = 1'b1;
      #1;
      n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL rstwb_state: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
      n_checks++; if (mem_en !== 1'b0) $display("FAIL rstwb_mem_en: got %b want 0", mem_en); else n_pass++;
      n_checks++; if (mem_addr !== 32'h0) $display("FAIL rstwb_mem_addr: got %h want 0", mem_addr); else n_pass++;
      idle_inputs();
      tick();
      rst = 1'b0;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      #1;
      n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL rstwb_ack_state: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
      n_checks++; if (mem_en !== 1'b0) $display("FAIL rstwb_ack_mem_en: got %b want 0", mem_en); else n_pass++;
      n_checks++; if (cpu_stall !== 1'b0) $display("FAIL rstwb_ack_stall: got %b want 0", cpu_stall); else n_pass++;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [255:0] la;
      logic [255:0] lb;
      logic [31:0]  seen_addr;
      logic [24:0]  seen_tag;
      la = make_line(32'hA000_0000);
      lb = make_line(32'hB000_0000);
      clean_miss(32'h0000_0060, la, seen_addr, seen_tag);
      n_checks++; if (seen_addr !== 32'h0000_0060) $display("FAIL b2b_a_mem_addr: got %h want 00000060", seen_addr); else n_pass++;
      n_checks++; if (seen_tag !== 25'h100_0000) $display("FAIL b2b_a_tag: got %h want 1000000", seen_tag); else n_pass++;
      n_checks++; if (cpu_rdata !== 32'hA000_0000) $display("FAIL b2b_a_replay: got %h want a0000000", cpu_rdata); else n_pass++;
      tick();
      clean_miss(32'h0000_1080, lb, seen_addr, seen_tag);
      n_checks++; if (seen_addr !== 32'h0000_1080) $display("FAIL b2b_b_mem_addr: got %h want 00001080", seen_addr); else n_pass++;
      n_checks++; if (seen_tag !== 25'h100_0008) $display("FAIL b2b_b_tag: got %h want 1000008", seen_tag); else n_pass++;
      n_checks++; if (cpu_rdata !== 32'hB000_0000) $display("FAIL b2b_b_replay: got %h want b0000000", cpu_rdata); else n_pass++;
      tick();
      cpu_addr = 32'h0000_0064; sram_hit = 1'b1; sram_data_i = la;
      #1;
      n_checks++; if ({cpu_stall, mem_en} !== 2'b00) $display("FAIL b2b_a_hit_ctl: got %b want 00", {cpu_stall, mem_en}); else n_pass++;
      n_checks++; if (cpu_rdata !== 32'hA000_0001) $display("FAIL b2b_a_hit_data: got %h want a0000001", cpu_rdata); else n_pass++;
      tick();
      cpu_addr = 32'h0000_108C; sram_hit = 1'b1; sram_data_i = lb;
      #1;
      n_checks++; if ({cpu_stall, mem_en} !== 2'b00) $display("FAIL b2b_b_hit_ctl: got %b want 00", {cpu_stall, mem_en}); else n_pass++;
      n_checks++; if (cpu_rdata !== 32'hB000_0003) $display("FAIL b2b_b_hit_data: got %h want b0000003", cpu_rdata); else n_pass++;
      tick();
      n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL b2b_final_state: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
      idle_inputs();
      tick();
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      mon_en   = 1'b0;
      mon_stall = 0;
      mon_wr   = 0;
      rst      = 1'b1;
      idle_inputs();
      @(posedge clk);
      #2;
      test_reset();
      @(negedge clk);
      rst = 1'b0;
      tick();
      test_cold_load();
      test_store_hit();
      test_dirty_victim();
      test_latency(1);
      test_latency(10);
      test_reset_mid_writeback();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
